mipi_csi_rx_lane_deskew: RTL and testbench
==========================================

Name: mipi_csi_rx_lane_deskew

Overview:
Parametrised successor to the fixed 4-lane/16-bit CSI-2 lane aligner. It sits between the per-lane byte aligners and the packet/lane-merge stage. It measures the arrival skew of each enabled lane at start of transmission and delays early lanes so all lanes present word 0 in the same cycle. It adds a runtime lane-count mask, skew-overflow error detection, per-lane skew reporting and a clean skewed end-of-burst.

Parameters:
LANES, 4, number of physical lanes (1..8)
LANE_WIDTH, 16, bits per lane per clock (8 or 16)
MAX_SKEW, 3, largest tolerated inter-lane arrival skew in clocks (1..15)
SKEW_W (localparam), clog2(MAX_SKEW+1), width of one skew field

Ports:
clk_i  in  1  byte clock
reset_n_i  in  1  synchronous active-low reset
lane_mask_i  in  LANES  enabled lanes (1/2/4-lane modes); sampled only in IDLE
bytes_valid_i  in  LANES  per-lane data valid from byte aligners
byte_i  in  LANES*LANE_WIDTH  lane k at [k*LANE_WIDTH +: LANE_WIDTH]
lane_valid_o  out  1  deskewed data valid
lane_byte_o  out  LANES*LANE_WIDTH  deskewed data; disabled lanes are 0
skew_error_o  out  1  one-cycle pulse: skew exceeded MAX_SKEW or a lane dropped during arming
lane_skew_o  out  LANES*SKEW_W  tap (delay) applied per lane; held until the next burst locks

Behaviour:
- Reset (reset_n_i=0 at an edge): state IDLE; all outputs 0; delay lines, counters, taps and arrival flags cleared. Reset mid-burst aborts the burst: lane_valid_o=0 after that edge.
- Each lane has a delay line d_k[0..MAX_SKEW] holding {valid, data}. d_k[0] registers the current input; d_k[i] is i cycles older.
- States: IDLE, ARMED, ALIGNED, DRAIN, WAIT_IDLE.
- IDLE: latch mask m = lane_mask_i. If m==0, stay IDLE. On the first edge where any enabled bytes_valid_i=1: counter c=0, record arrival_k=0 for those lanes, go to ARMED. If every enabled lane is valid on that edge, lock immediately (see lock).
- ARMED: c increments each edge. A lane first seen valid records arrival_k=c.
  - Lock: on the edge where the last enabled lane arrives, set tap_k = c_last - arrival_k, update lane_skew_o and go to ALIGNED.
  - If c reaches MAX_SKEW and an enabled lane is still missing, or an arrived lane drops valid: pulse skew_error_o at the next edge and go to WAIT_IDLE.
- ALIGNED: per edge, lane_byte_o[k] <= d_k[tap_k].data for enabled lanes, else 0. lane_valid_o <= AND over enabled k of d_k[tap_k].valid.
  - Latency: 2 clocks from the last lane's first valid sample to lane_valid_o=1 with word 0 on every lane.
  - When that AND first becomes 0: lane_valid_o <= 0 and go to DRAIN. No partial words are output after that.
- DRAIN / WAIT_IDLE: outputs 0 except lane_skew_o. Return to IDLE on the first edge where all enabled bytes_valid_i=0. A lane re-asserting valid here is ignored.
- Disabled lanes: inputs are fully ignored and never cause arming or errors. Their lane_skew_o field is 0.
- skew_error_o is never asserted together with lane_valid_o.

Decomposition:
- Package csi_rx_pkg: deskew state enum; default LANES/LANE_WIDTH/MAX_SKEW constants; the clog2 helper.
- Sub-module mipi_csi_rx_lane_delay: one lane's {valid,data} delay line with a registered tap select. Instantiated LANES times by a generate loop.
- Arrival tracking, counter and state machine stay in the top module.

Test Plan:
- No skew, LANES=4, mask=4'hF: all lanes valid together carrying 11B8,3322,5544,7766,9988 -> lane_valid_o high 2 clocks later for exactly 5 cycles; lane_byte_o = 64'h11B811B811B811B8 first; lane_skew_o all 0; no error.
- Skew: lane1 valid at t; lanes 0,2 at t+2; lane3 at t+3; valid drops in the same skewed order -> lane_skew_o = {0,1,3,1} (lanes 3..0); first output word 11B8 on all lanes; exactly 5 valid output words; returns to IDLE.
- Overflow, MAX_SKEW=3: lane3 arrives 4 clocks after lane0 -> single skew_error_o pulse; lane_valid_o never 1; IDLE once all lanes are low; the next clean burst aligns correctly.
- 2-lane mode, mask=4'b0011: lanes 2,3 toggle random data -> only lanes 0,1 are aligned; lane_byte_o[63:32]=0; output behaviour is unaffected by lanes 2,3.
- Reset mid-burst: reset_n_i=0 for one edge during ALIGNED -> lane_valid_o=0 and all outputs 0 at that edge; a following burst locks normally.
- Arming glitch: lane0 valid one cycle then low before lane1 arrives -> skew_error_o pulse; wait for all lanes low; IDLE.

Source files
------------

// File: rtl/csi_rx_pkg.sv
// Shared types and constants for the CSI-2 receive lane deskew block.
package csi_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARMED     = 3'd1,
    ST_ALIGNED   = 3'd2,
    ST_DRAIN     = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } deskew_state_e;

  localparam int DEF_LANES      = 4;
  localparam int DEF_LANE_WIDTH = 16;
  localparam int DEF_MAX_SKEW   = 3;

  // Ceiling log2, never below 1 so single-value fields still get a bit.
  function automatic int clog2_f(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        res = i + 1;
      end else begin
        res = res;
      end
    end
    return (res < 1) ? 1 : res;
  endfunction

endpackage

// File: rtl/mipi_csi_rx_lane_deskew_if.sv
// Bus between the per-lane byte aligners, the deskew block and the lane-merge stage.
interface mipi_csi_rx_lane_deskew_if
  import csi_rx_pkg::*;
#(
  parameter int LANES      = DEF_LANES,
  parameter int LANE_WIDTH = DEF_LANE_WIDTH,
  parameter int MAX_SKEW   = DEF_MAX_SKEW
);
  localparam int SKEW_W = clog2_f(MAX_SKEW + 1);

  logic [LANES-1:0]            lane_mask_i;
  logic [LANES-1:0]            bytes_valid_i;
  logic [LANES*LANE_WIDTH-1:0] byte_i;
  logic                        lane_valid_o;
  logic [LANES*LANE_WIDTH-1:0] lane_byte_o;
  logic                        skew_error_o;
  logic [LANES*SKEW_W-1:0]     lane_skew_o;

  modport master (
    output lane_mask_i, bytes_valid_i, byte_i,
    input  lane_valid_o, lane_byte_o, skew_error_o, lane_skew_o
  );

  modport slave (
    input  lane_mask_i, bytes_valid_i, byte_i,
    output lane_valid_o, lane_byte_o, skew_error_o, lane_skew_o
  );

endinterface

// File: rtl/mipi_csi_rx_lane_deskew_lane_delay.sv
// One lane's {valid,data} delay line; the tapped word is registered so the
// selected tap and the data leave this module on the same clock.
module mipi_csi_rx_lane_delay #(
  parameter int LANE_WIDTH = 16,
  parameter int MAX_SKEW   = 3,
  parameter int SKEW_W     = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  valid_i,
  input  logic [LANE_WIDTH-1:0] data_i,
  input  logic                  tap_load_i,
  input  logic [SKEW_W-1:0]     tap_i,
  output logic [SKEW_W-1:0]     tap_o,
  output logic                  valid_o,
  output logic [LANE_WIDTH-1:0] data_o
);

  logic [LANE_WIDTH:0] line_r [MAX_SKEW+1];
  logic [SKEW_W-1:0]   tap_r;
  logic [LANE_WIDTH:0] sel_r;

  // Shift line, tap register and tapped-word register.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i <= MAX_SKEW; i++) begin
        line_r[i] <= '0;
      end
      tap_r <= '0;
      sel_r <= '0;
    end else begin
      line_r[0] <= {valid_i, data_i};
      for (int i = 1; i <= MAX_SKEW; i++) begin
        line_r[i] <= line_r[i-1];
      end
      tap_r <= tap_load_i ? tap_i : tap_r;
      sel_r <= line_r[tap_r];
    end
  end

  assign tap_o   = tap_r;
  assign valid_o = sel_r[LANE_WIDTH];
  assign data_o  = sel_r[LANE_WIDTH-1:0];

endmodule

// File: rtl/mipi_csi_rx_lane_deskew.sv
// Measures per-lane arrival skew at start of burst and delays early lanes so
// every enabled lane presents word 0 in the same cycle.
module mipi_csi_rx_lane_deskew
  import csi_rx_pkg::*;
#(
  parameter int LANES      = DEF_LANES,
  parameter int LANE_WIDTH = DEF_LANE_WIDTH,
  parameter int MAX_SKEW   = DEF_MAX_SKEW
) (
  input  logic clk_i,
  input  logic reset_n_i,
  mipi_csi_rx_lane_deskew_if.slave bus
);

  localparam int SKEW_W = clog2_f(MAX_SKEW + 1);
  localparam logic [SKEW_W-1:0] SKEW_LIMIT = SKEW_W'(MAX_SKEW);
  localparam int DW = LANES * LANE_WIDTH;

  deskew_state_e        state_r, state_nxt;
  logic [LANES-1:0]     mask_r, mask_nxt;
  logic [LANES-1:0]     arr_r, arr_nxt;
  logic [SKEW_W-1:0]    cnt_r, cnt_nxt, cnt_inc_s;
  logic [SKEW_W-1:0]    arrival_r [LANES];
  logic [SKEW_W-1:0]    arrival_nxt [LANES];
  logic                 prime_r, prime_nxt;
  logic                 lock_s;
  logic [SKEW_W-1:0]    tap_s [LANES];
  logic [LANES-1:0]     vm_s, new_s;
  logic                 drop_s;
  logic [LANES-1:0]     tap_valid_s;
  logic [DW-1:0]        tap_data_s;
  logic [LANES*SKEW_W-1:0] skew_s;
  logic                 aligned_and_s;
  logic                 valid_r, valid_nxt;
  logic [DW-1:0]        byte_r, byte_nxt;
  logic                 err_r, err_nxt;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    mipi_csi_rx_lane_delay #(
      .LANE_WIDTH (LANE_WIDTH),
      .MAX_SKEW   (MAX_SKEW),
      .SKEW_W     (SKEW_W)
    ) u_delay (
      .clk_i      (clk_i),
      .reset_n_i  (reset_n_i),
      .valid_i    (bus.bytes_valid_i[k]),
      .data_i     (bus.byte_i[k*LANE_WIDTH +: LANE_WIDTH]),
      .tap_load_i (lock_s),
      .tap_i      (tap_s[k]),
      .tap_o      (skew_s[k*SKEW_W +: SKEW_W]),
      .valid_o    (tap_valid_s[k]),
      .data_o     (tap_data_s[k*LANE_WIDTH +: LANE_WIDTH])
    );
  end

  assign aligned_and_s = &(tap_valid_s | ~mask_r);
  assign cnt_inc_s     = cnt_r + SKEW_W'(1);

  // Next-state, arrival tracking, tap computation and output next-values.
  always_comb begin
    state_nxt   = state_r;
    mask_nxt    = mask_r;
    arr_nxt     = arr_r;
    cnt_nxt     = cnt_r;
    arrival_nxt = arrival_r;
    prime_nxt   = prime_r;
    lock_s      = 1'b0;
    valid_nxt   = 1'b0;
    byte_nxt    = '0;
    err_nxt     = 1'b0;
    vm_s        = bus.bytes_valid_i & mask_r;
    new_s       = vm_s & ~arr_r;
    drop_s      = |(arr_r & ~vm_s);
    for (int k = 0; k < LANES; k++) begin
      tap_s[k] = '0;
    end
    case (state_r)
      ST_IDLE: begin
        mask_nxt = bus.lane_mask_i;
        vm_s     = bus.bytes_valid_i & bus.lane_mask_i;
        cnt_nxt  = '0;
        arr_nxt  = vm_s;
        for (int k = 0; k < LANES; k++) begin
          arrival_nxt[k] = '0;
        end
        if (vm_s != '0) begin
          // All enabled lanes together: zero taps, lock straight away.
          if (vm_s == bus.lane_mask_i) begin
            lock_s    = 1'b1;
            prime_nxt = 1'b1;
            state_nxt = ST_ALIGNED;
          end else begin
            state_nxt = ST_ARMED;
          end
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_ARMED: begin
        cnt_nxt = cnt_inc_s;
        arr_nxt = arr_r | new_s;
        for (int k = 0; k < LANES; k++) begin
          arrival_nxt[k] = new_s[k] ? cnt_inc_s : arrival_r[k];
        end
        if (drop_s) begin
          err_nxt   = 1'b1;
          state_nxt = ST_WAIT_IDLE;
        end else if ((arr_r | new_s) == mask_r) begin
          lock_s    = 1'b1;
          prime_nxt = 1'b1;
          state_nxt = ST_ALIGNED;
          for (int k = 0; k < LANES; k++) begin
            tap_s[k] = mask_r[k] ? (cnt_inc_s - (new_s[k] ? cnt_inc_s : arrival_r[k])) : '0;
          end
        end else if (cnt_inc_s >= SKEW_LIMIT) begin
          err_nxt   = 1'b1;
          state_nxt = ST_WAIT_IDLE;
        end else begin
          state_nxt = ST_ARMED;
        end
      end
      ST_ALIGNED: begin
        // First cycle after lock the tapped register still holds pre-lock data.
        if (prime_r) begin
          prime_nxt = 1'b0;
        end else if (aligned_and_s) begin
          valid_nxt = 1'b1;
          for (int k = 0; k < LANES; k++) begin
            byte_nxt[k*LANE_WIDTH +: LANE_WIDTH] =
              mask_r[k] ? tap_data_s[k*LANE_WIDTH +: LANE_WIDTH] : '0;
          end
        end else begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN, ST_WAIT_IDLE: begin
        if (vm_s == '0) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = state_r;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r <= ST_IDLE;
      mask_r  <= '0;
      arr_r   <= '0;
      cnt_r   <= '0;
      prime_r <= 1'b0;
      valid_r <= 1'b0;
      byte_r  <= '0;
      err_r   <= 1'b0;
      for (int k = 0; k < LANES; k++) begin
        arrival_r[k] <= '0;
      end
    end else begin
      state_r   <= state_nxt;
      mask_r    <= mask_nxt;
      arr_r     <= arr_nxt;
      cnt_r     <= cnt_nxt;
      prime_r   <= prime_nxt;
      valid_r   <= valid_nxt;
      byte_r    <= byte_nxt;
      err_r     <= err_nxt;
      arrival_r <= arrival_nxt;
    end
  end

  assign bus.lane_valid_o = valid_r;
  assign bus.lane_byte_o  = byte_r;
  assign bus.skew_error_o = err_r;
  assign bus.lane_skew_o  = skew_s;

endmodule

// File: tb/tb_mipi_csi_rx_lane_deskew.sv
// Randomised bench for the lane deskew block against a burst-level model.
module tb_mipi_csi_rx_lane_deskew;

  localparam int LANES = 4;
  localparam int LW    = 16;
  localparam int MS    = 3;
  localparam int SW    = 2;

  logic clk;
  logic reset_n;
  int   assert_cnt;
  int   fail_cnt;

  int          s_arr [LANES];
  int          l_arr [LANES];
  logic [15:0] words [LANES][16];
  logic [15:0] fixed_words [5];
  logic [7:0]  last_skew;

  mipi_csi_rx_lane_deskew_if #(.LANES(LANES), .LANE_WIDTH(LW), .MAX_SKEW(MS)) bus ();

  mipi_csi_rx_lane_deskew #(.LANES(LANES), .LANE_WIDTH(LW), .MAX_SKEW(MS)) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    assert_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Drive one burst from s_arr/l_arr and compare against burst-level expectations.
  task automatic run_burst(input logic [3:0] mask, input bit fixed, input bit noise, input int rst_at);
    int s_min, s_max, max_e, min_l, total, first_t, errs, overlap;
    bit exp_err;
    logic [7:0]  exp_skew;
    logic [63:0] exp_word;
    logic [63:0] obs [$];
    s_min = 1000; s_max = 0; max_e = 0; min_l = 1000; exp_err = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      for (int i = 0; i < 16; i++) begin
        words[k][i] = (fixed && i < 5) ? fixed_words[i] : 16'($urandom);
      end
      if (mask[k]) begin
        if (s_arr[k] < s_min) s_min = s_arr[k];
        if (s_arr[k] > s_max) s_max = s_arr[k];
        if (s_arr[k] + l_arr[k] > max_e) max_e = s_arr[k] + l_arr[k];
        if (l_arr[k] < min_l) min_l = l_arr[k];
      end
    end
    if (s_max - s_min > MS) exp_err = 1'b1;
    exp_skew = 8'h00;
    for (int k = 0; k < LANES; k++) begin
      if (mask[k]) begin
        if (s_arr[k] + l_arr[k] <= s_max) exp_err = 1'b1;
        exp_skew[k*SW +: SW] = SW'(s_max - s_arr[k]);
      end
    end
    total = max_e + 10; first_t = -1; errs = 0; overlap = 0;
    for (int t = 0; t < total; t++) begin
      bus.lane_mask_i = mask;
      reset_n = (t == rst_at) ? 1'b0 : 1'b1;
      for (int k = 0; k < LANES; k++) begin
        if (mask[k]) begin
          if (t >= s_arr[k] && t < s_arr[k] + l_arr[k] && !(rst_at >= 0 && t >= rst_at)) begin
            bus.bytes_valid_i[k] = 1'b1;
            bus.byte_i[k*LW +: LW] = words[k][t - s_arr[k]];
          end else begin
            bus.bytes_valid_i[k] = 1'b0;
            bus.byte_i[k*LW +: LW] = 16'($urandom);
          end
        end else begin
          bus.bytes_valid_i[k] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
          bus.byte_i[k*LW +: LW] = noise ? 16'($urandom) : 16'h0000;
        end
      end
      @(posedge clk);
      #1;
      if (t == rst_at) begin
        check_eq("rst_valid", 64'(bus.lane_valid_o), 64'd0);
        check_eq("rst_byte", bus.lane_byte_o, 64'd0);
        check_eq("rst_err", 64'(bus.skew_error_o), 64'd0);
        check_eq("rst_skew", 64'(bus.lane_skew_o), 64'd0);
      end
      if (bus.lane_valid_o) begin
        if (first_t < 0) first_t = t;
        obs.push_back(bus.lane_byte_o);
      end
      if (bus.skew_error_o) errs++;
      if (bus.skew_error_o && bus.lane_valid_o) overlap++;
    end
    check_eq("err_with_valid", 64'(overlap), 64'd0);
    if (rst_at >= 0) begin
      last_skew = 8'h00;
    end else if (exp_err) begin
      check_eq("err_pulses", 64'(errs), 64'd1);
      check_eq("err_no_words", 64'(obs.size()), 64'd0);
      check_eq("err_skew_held", 64'(bus.lane_skew_o), 64'(last_skew));
    end else begin
      last_skew = exp_skew;
      check_eq("no_err", 64'(errs), 64'd0);
      check_eq("latency", 64'(first_t), 64'(s_max + 2));
      check_eq("word_count", 64'(obs.size()), 64'(min_l));
      check_eq("lane_skew", 64'(bus.lane_skew_o), 64'(exp_skew));
      for (int i = 0; i < obs.size() && i < min_l; i++) begin
        exp_word = 64'd0;
        for (int k = 0; k < LANES; k++) begin
          if (mask[k]) exp_word[k*LW +: LW] = words[k][i];
        end
        check_eq("word", obs[i], exp_word);
      end
    end
  endtask

  task automatic set_lane(input int k, input int s, input int l);
    s_arr[k] = s;
    l_arr[k] = l;
  endtask

  initial begin
    logic [3:0] mask;
    int smax;
    assert_cnt = 0;
    fail_cnt   = 0;
    last_skew  = 8'h00;
    fixed_words[0] = 16'h11B8; fixed_words[1] = 16'h3322; fixed_words[2] = 16'h5544;
    fixed_words[3] = 16'h7766; fixed_words[4] = 16'h9988;
    reset_n = 1'b0;
    bus.lane_mask_i   = 4'h0;
    bus.bytes_valid_i = 4'h0;
    bus.byte_i        = 64'd0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_valid", 64'(bus.lane_valid_o), 64'd0);
    check_eq("reset_byte", bus.lane_byte_o, 64'd0);
    check_eq("reset_err", 64'(bus.skew_error_o), 64'd0);
    check_eq("reset_skew", 64'(bus.lane_skew_o), 64'd0);
    reset_n = 1'b1;

    // No skew, fixed words.
    for (int k = 0; k < LANES; k++) set_lane(k, 2, 5);
    run_burst(4'hF, 1'b1, 1'b0, -1);
    // Lane1 first, lanes 0/2 two later, lane3 three later.
    set_lane(0, 4, 5); set_lane(1, 2, 5); set_lane(2, 4, 5); set_lane(3, 5, 5);
    run_burst(4'hF, 1'b1, 1'b0, -1);
    // Lane3 four clocks after lane0.
    set_lane(0, 2, 8); set_lane(1, 3, 8); set_lane(2, 3, 8); set_lane(3, 6, 6);
    run_burst(4'hF, 1'b0, 1'b0, -1);
    // Clean burst right after the overflow.
    set_lane(0, 2, 6); set_lane(1, 3, 6); set_lane(2, 2, 6); set_lane(3, 4, 6);
    run_burst(4'hF, 1'b0, 1'b0, -1);
    // Two-lane mode with noisy disabled lanes.
    set_lane(0, 3, 6); set_lane(1, 2, 7); set_lane(2, 0, 0); set_lane(3, 0, 0);
    run_burst(4'b0011, 1'b0, 1'b1, -1);
    // Reset while aligned.
    set_lane(0, 2, 8); set_lane(1, 3, 8); set_lane(2, 2, 8); set_lane(3, 4, 8);
    run_burst(4'hF, 1'b0, 1'b0, 7);
    set_lane(0, 3, 5); set_lane(1, 2, 6); set_lane(2, 2, 6); set_lane(3, 3, 5);
    run_burst(4'hF, 1'b0, 1'b0, -1);
    // Arming glitch on lane0.
    set_lane(0, 2, 1); set_lane(1, 3, 4); set_lane(2, 3, 4); set_lane(3, 3, 4);
    run_burst(4'hF, 1'b0, 1'b0, -1);

    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 3))
        0: mask = 4'h1;
        1: mask = 4'h3;
        2: mask = 4'hF;
        default: mask = 4'($urandom_range(1, 15));
      endcase
      smax = 0;
      for (int k = 0; k < LANES; k++) begin
        s_arr[k] = 2 + int'($urandom_range(0, MS));
        if (mask[k] && s_arr[k] > smax) smax = s_arr[k];
      end
      for (int k = 0; k < LANES; k++) begin
        l_arr[k] = smax - s_arr[k] + int'($urandom_range(1, 6));
      end
      run_burst(mask, 1'b0, 1'($urandom_range(0, 1)), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
